// File: rtl/gfp8_nv_dot.sv
// GFP8 native-vector dot product: 4 groups x 32 int8 mantissas with a shared exponent per group.
// Latency is 3 edges. `define GFP8_NV_DOT_VALID_OUT_EN to add the o_result_valid strobe.
module gfp8_nv_lane #(
  parameter int VEC_W    = 32,
  parameter int EXP_BIAS = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cap,
  input  logic                  i_sum_en,
  input  logic [7:0]            i_exp_l,
  input  logic [7:0]            i_exp_r,
  input  logic [VEC_W*8-1:0]    i_man_l,
  input  logic [VEC_W*8-1:0]    i_man_r,
  output logic signed [31:0]    o_psum,
  output logic signed [7:0]     o_exp
);
  logic signed [15:0] prod_d [VEC_W];
  logic signed [15:0] prod_q [VEC_W];
  logic [4:0]         el_q, er_q;
  logic signed [31:0] psum_d, psum_q;
  logic signed [7:0]  e_d, e_q;
  logic               unused_exp_bits;

  assign unused_exp_bits = ^{i_exp_l[7:5], i_exp_r[7:5]};

  always_comb begin
    for (int i = 0; i < VEC_W; i++)
      prod_d[i] = 16'($signed(i_man_l[8*i +: 8])) * 16'($signed(i_man_r[8*i +: 8]));
    psum_d = '0;
    for (int i = 0; i < VEC_W; i++)
      psum_d = psum_d + 32'(prod_q[i]);
    // Both biases come off at once; 8-bit wrap leaves the correct signed value.
    e_d = 8'({3'b0, el_q}) + 8'({3'b0, er_q}) - 8'(2*EXP_BIAS);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < VEC_W; i++) prod_q[i] <= '0;
      el_q   <= '0;
      er_q   <= '0;
      psum_q <= '0;
      e_q    <= '0;
    end else begin
      if (i_cap) begin
        prod_q <= prod_d;
        el_q   <= i_exp_l[4:0];
        er_q   <= i_exp_r[4:0];
      end
      if (i_sum_en) begin
        psum_q <= psum_d;
        e_q    <= e_d;
      end
    end
  end

  assign o_psum = psum_q;
  assign o_exp  = e_q;
endmodule

module gfp8_nv_dot #(
  parameter int EXP_BIAS = 15
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_input_valid,
  input  logic [31:0]         i_exp_left,
  input  logic [255:0]        i_man_left  [0:3],
  input  logic [31:0]         i_exp_right,
  input  logic [255:0]        i_man_right [0:3],
`ifdef GFP8_NV_DOT_VALID_OUT_EN
  output logic                o_result_valid,
`endif
  output logic signed [31:0]  o_result_mantissa,
  output logic signed [7:0]   o_result_exponent
);
  localparam int NUM_LANES = 4;

  logic [1:0]         vld_pipe_q;
  logic signed [31:0] psum [NUM_LANES];
  logic signed [7:0]  eg   [NUM_LANES];
  logic signed [7:0]  emax_d, sh;
  logic signed [31:0] man_d;
  logic signed [31:0] man_q;
  logic signed [7:0]  exp_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gfp8_nv_lane #(.VEC_W(32), .EXP_BIAS(EXP_BIAS)) u_lane (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .i_cap    (i_input_valid),
      .i_sum_en (vld_pipe_q[0]),
      .i_exp_l  (i_exp_left[8*g +: 8]),
      .i_exp_r  (i_exp_right[8*g +: 8]),
      .i_man_l  (i_man_left[g]),
      .i_man_r  (i_man_right[g]),
      .o_psum   (psum[g]),
      .o_exp    (eg[g])
    );
  end

  always_comb begin
    emax_d = eg[0];
    for (int g = 1; g < NUM_LANES; g++)
      if (eg[g] > emax_d) emax_d = eg[g];
    man_d = '0;
    sh    = '0;
    for (int g = 0; g < NUM_LANES; g++) begin
      // Shift is 0..62; anything past 31 has no surviving bits worth keeping.
      sh = emax_d - eg[g];
      if (sh <= 8'sd31) man_d = man_d + (psum[g] >>> sh[4:0]);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_pipe_q <= '0;
      man_q      <= '0;
      exp_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], i_input_valid};
      if (vld_pipe_q[1]) begin
        man_q <= man_d;
        exp_q <= emax_d;
      end
    end
  end

`ifdef GFP8_NV_DOT_VALID_OUT_EN
  logic vld_out_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) vld_out_q <= 1'b0;
    else            vld_out_q <= vld_pipe_q[1];
  end
  assign o_result_valid = vld_out_q;
`endif

  assign o_result_mantissa = man_q;
  assign o_result_exponent = exp_q;
endmodule

// File: tb/tb_gfp8_nv_dot.sv
// Randomized + directed bench for gfp8_nv_dot against a group-level arithmetic model.
module tb_gfp8_nv_dot;
  logic               i_clk = 1'b0;
  logic               i_reset_n;
  logic               i_input_valid;
  logic [31:0]        i_exp_left, i_exp_right;
  logic [255:0]       i_man_left  [0:3];
  logic [255:0]       i_man_right [0:3];
  logic signed [31:0] o_result_mantissa;
  logic signed [7:0]  o_result_exponent;
  logic               vout;

  gfp8_nv_dot dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_input_valid    (i_input_valid),
    .i_exp_left       (i_exp_left),
    .i_man_left       (i_man_left),
    .i_exp_right      (i_exp_right),
    .i_man_right      (i_man_right),
`ifdef GFP8_NV_DOT_VALID_OUT_EN
    .o_result_valid   (vout),
`endif
    .o_result_mantissa(o_result_mantissa),
    .o_result_exponent(o_result_exponent)
  );

`ifndef GFP8_NV_DOT_VALID_OUT_EN
  assign vout = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  typedef struct { int due; int m; int e; } exp_t;
  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;
  int   cur_m = 0, cur_e = 0;

  task automatic chk(input string tag, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, req, cyc);
    end
  endtask

  // Reference: exact group dot products aligned to the largest group exponent.
  task automatic model(output int m, output int e);
    int p [4];
    int eg [4];
    int emax, sh;
    for (int g = 0; g < 4; g++) begin
      p[g] = 0;
      for (int i = 0; i < 32; i++)
        p[g] += int'($signed(i_man_left[g][8*i +: 8])) * int'($signed(i_man_right[g][8*i +: 8]));
      eg[g] = (int'(i_exp_left[8*g +: 5]) - 15) + (int'(i_exp_right[8*g +: 5]) - 15);
    end
    emax = eg[0];
    for (int g = 1; g < 4; g++) if (eg[g] > emax) emax = eg[g];
    m = 0;
    for (int g = 0; g < 4; g++) begin
      sh = emax - eg[g];
      if (sh <= 31) m += p[g] >>> sh;
    end
    e = emax;
  endtask

  task automatic step(input bit v);
    exp_t t;
    bit   popped;
    i_input_valid = v;
    if (v) begin
      model(t.m, t.e);
      t.due = cyc + 3;
      q.push_back(t);
    end
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    i_input_valid = 1'b0;
    popped = 1'b0;
    while (q.size() > 0 && q[0].due <= cyc) begin
      t = q.pop_front();
      cur_m = t.m;
      cur_e = t.e;
      popped = 1'b1;
    end
    chk("man", o_result_mantissa, cur_m);
    chk("exp", int'(o_result_exponent), cur_e);
`ifdef GFP8_NV_DOT_VALID_OUT_EN
    chk("vld", int'(vout), int'(popped));
`endif
  endtask

  task automatic set_all(input logic [7:0] ml, input logic [7:0] mr,
                         input logic [7:0] el, input logic [7:0] er);
    for (int g = 0; g < 4; g++) begin
      i_man_left[g]  = {32{ml}};
      i_man_right[g] = {32{mr}};
    end
    i_exp_left  = {4{el}};
    i_exp_right = {4{er}};
  endtask

  task automatic randomize_in();
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 8; i++) begin
        i_man_left[g][32*i +: 32]  = $urandom;
        i_man_right[g][32*i +: 32] = $urandom;
      end
    i_exp_left  = $urandom;
    i_exp_right = $urandom;
  endtask

  // One pulse, then let it drain and pin the result against a hand-derived value.
  task automatic directed(input string tag, input int m, input int e);
    step(1'b1);
    for (int k = 0; k < 4; k++) step(1'b0);
    chk({tag, "_m"}, o_result_mantissa, m);
    chk({tag, "_e"}, int'(o_result_exponent), e);
  endtask

  initial begin
    i_reset_n     = 1'b0;
    i_input_valid = 1'b0;
    set_all(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_m", o_result_mantissa, 0);
    chk("rst_e", int'(o_result_exponent), 0);
    chk("rst_v", int'(vout), 0);
    i_reset_n = 1'b1;
    step(1'b0);

    set_all(8'h01, 8'h01, 8'h0F, 8'h0F);
    directed("ones", 128, 0);
    set_all(8'h01, 8'h01, 8'h0F, 8'h0F);
    i_exp_left[7:0] = 8'h10;
    directed("g0up", 80, 1);
    set_all(8'hFF, 8'h02, 8'h0F, 8'h0F);
    directed("neg", -256, 0);
    i_exp_left[7:0] = 8'h10;
    directed("negup", -160, 1);
    set_all(8'h01, 8'h01, 8'h00, 8'h00);
    i_exp_left[7:0]  = 8'h1F;
    i_exp_right[7:0] = 8'h1F;
    directed("bigsh", 32, 32);
    set_all(8'h80, 8'h80, 8'hEF, 8'h0F);
    directed("minmin", 2097152, 0);

    randomize_in(); step(1'b1);
    randomize_in(); step(1'b1);
    for (int k = 0; k < 4; k++) step(1'b0);

    randomize_in(); step(1'b1);
    i_reset_n = 1'b0;
    #1;
    q.delete();
    cur_m = 0;
    cur_e = 0;
    chk("arst_m", o_result_mantissa, 0);
    chk("arst_e", int'(o_result_exponent), 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b0);

    for (int k = 0; k < 400; k++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      if (v) randomize_in();
      step(v);
    end
    for (int k = 0; k < 4; k++) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
